fp_addsub_seq: RTL and testbench
================================

# fp_addsub_seq

Multi-cycle sequencer for floating-point add/subtract on packed operands of width 1+EXP_SIZE+MANTIS_SIZE. It accepts one operation at a time over a valid/ready handshake and runs it through unpack/swap, serial alignment, add/subtract, serial normalization and optional rounding. It returns the packed result with status flags. It sits between the operand-issue logic and the result writeback path, and sequences the single-cycle mantissa adder datapath.

## Interface
- EXP_SIZE, default `EXP_SIZE: exponent width.
- MANTIS_SIZE, default `MANTIS_SIZE: stored fraction width; internal extended mantissa is MANTIS_SIZE+3 bits, {hidden, fraction, guard, sticky}.
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and op valid.
- in_ready  output  1  block idle and able to accept.
- op  input  1  0 = A+B, 1 = A−B.
- a, b  input  1+EXP_SIZE+MANTIS_SIZE  packed operands {sign, exp, frac}.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts result.
- result  output  1+EXP_SIZE+MANTIS_SIZE  packed result.
- flags  output  4  {overflow, underflow, zero, inexact}.

## Operation
- States: IDLE, ALIGN, ADD, NORM, ROUND, DONE. in_ready=1 only in IDLE.
- **IDLE:** on in_valid, the block captures the operands and applies b_sign ^= op.
  - exp==0 operands are treated as zero (fraction ignored).
  - If either exp is all-ones, the result is that operand (a has priority), flags=0, next state DONE.
  - Otherwise, if {exp,frac} of b > a, swap them so the larger operand becomes X. The other operand is Y.
  - eff_sub = sX^sY. d = expX−expY, clamped to MANTIS_SIZE+3. Next state ALIGN.
- **ALIGN:** if d==0, go to ADD. Otherwise shift Y right 1 bit, OR the shifted-out bit into sticky, and decrement d. One bit per cycle.
- **ADD:** mX ± mY with carry.
  - carry=1: shift right 1 (sticky-preserving) and exp+1. If exp becomes all-ones: result = ±inf, overflow=1, go to DONE.
  - Result mantissa 0: +0, zero=1, go to DONE.
  - Else go to NORM.
- **NORM:** while hidden==0 and exp>1, shift left 1 and decrement exp, one per cycle.
  - If hidden==0 at exp==1: flush to signed zero, underflow=1, zero=1, go to DONE.
  - Otherwise go to ROUND.
- **ROUND:** inexact = guard|sticky.
  - With rounding compiled in: round-to-nearest-even, incrementing when guard & (sticky | lsb).
  - Increment overflow renormalizes and sets exp+1. An all-ones exponent gives ±inf with overflow=1.
- **DONE:** out_valid=1 with result/flags stable. On out_ready, go to IDLE.
- Result sign = sign of X, except an exact-zero result, which is +0.

## Timing
- Reset (async, any state): state=IDLE, in_ready=1 after reset release, out_valid=0, result=0, flags=0. An in-flight operation is discarded.
- Latency from accept edge to out_valid = 5 + d + n cycles, where n = normalization shifts (4 + d + n without rounding).
- Special-operand path: out_valid 1 cycle after accept.
- Zero/overflow short paths: 3 + d cycles.
- out_valid held with stable outputs while out_ready=0. On the handshake cycle the block returns to IDLE, and in_ready rises the next cycle (no same-cycle reissue).
- Maximum align steps: MANTIS_SIZE+3. Maximum normalize steps: MANTIS_SIZE+2.

## Configuration
- FP_ROUND_EN defined: ROUND state present; round-to-nearest-even as above.
- FP_ROUND_EN undefined: truncation; NORM goes directly to DONE; the inexact flag is still computed from guard|sticky; latency is 1 cycle shorter.

## Structure
- State encoding localparams, flag bit indices (FLAG_OF=3, FLAG_UF=2, FLAG_ZERO=1, FLAG_INEXACT=0) and the extended-mantissa width go in the shared header alongside configuration.v.
- One sub-module: fp_round_unit, a combinational RNE increment plus renormalize/overflow detect, instantiated only under FP_ROUND_EN.

## Test plan
(EXP_SIZE=8, MANTIS_SIZE=23)
- a=0x3F800000, b=0x3F800000, op=0 → result 0x40000000, flags=0, out_valid 5 cycles after accept.
- a=0x3FC00000, b=0x3FC00000, op=1 → result 0x00000000, flags=0010, out_valid 3 cycles after accept.
- a=0x3F800000, b=0x33C00000, op=0 → 24 ALIGN cycles. With FP_ROUND_EN: 0x3F800001, inexact=1. Without: 0x3F800000, inexact=1.
- a=0x7F7FFFFF, b=0x7F7FFFFF, op=0 → 0x7F800000, overflow=1.
- a=0x3F800000, b=0x30800000 (d=30 clamped to 26) → 26 ALIGN cycles, then 0x3F800000, inexact=1.
- Hold out_ready=0 for 10 cycles, then pulse; assert rst_n=0 mid-ALIGN → result/flags stable while held; in_ready=1 one cycle after handshake; after reset, out_valid=0 and the next operation computes correctly.

Source files
------------

// File: rtl/fp_addsub_seq_pkg.sv
// Shared widths, flag indices and FSM state type for fp_addsub_seq.
// Default sizes come from EXP_SIZE / MANTIS_SIZE macros (8 / 23 when not supplied).
`ifndef EXP_SIZE
`define EXP_SIZE 8
`endif
`ifndef MANTIS_SIZE
`define MANTIS_SIZE 23
`endif

package fp_addsub_seq_pkg;

  localparam int unsigned DEF_EXP_SIZE    = `EXP_SIZE;
  localparam int unsigned DEF_MANTIS_SIZE = `MANTIS_SIZE;
  // Extended mantissa: {hidden, fraction, guard, sticky}
  localparam int unsigned DEF_EXT_W       = DEF_MANTIS_SIZE + 3;

  localparam int unsigned FLAG_W       = 4;
  localparam int unsigned FLAG_OF      = 3;
  localparam int unsigned FLAG_UF      = 2;
  localparam int unsigned FLAG_ZERO    = 1;
  localparam int unsigned FLAG_INEXACT = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    ROUND = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/fp_addsub_seq_round.sv
// Combinational round-to-nearest-even on the extended mantissa, with
// renormalization on increment carry and all-ones exponent detection.
module fp_round_unit #(
  parameter int unsigned EXP_SIZE    = 8,
  parameter int unsigned MANTIS_SIZE = 23
) (
  input  logic [MANTIS_SIZE+2:0] mant,
  input  logic [EXP_SIZE-1:0]    expo,
  output logic [MANTIS_SIZE-1:0] frac,
  output logic [EXP_SIZE-1:0]    expo_rnd,
  output logic                   ovf
);

  localparam int unsigned SW = MANTIS_SIZE + 1;

  logic          inc;
  logic          carry;
  logic [SW-1:0] sum;

  always_comb begin
    inc          = mant[1] & (mant[0] | mant[2]);
    {carry, sum} = {1'b0, mant[MANTIS_SIZE+2:2]} + (SW+1)'(inc);
    // A carry out means 1.111..1 rolled over to 10.000..0
    frac         = carry ? sum[SW-1:1] : sum[MANTIS_SIZE-1:0];
    expo_rnd     = carry ? expo + EXP_SIZE'(1) : expo;
    ovf          = (expo_rnd == {EXP_SIZE{1'b1}});
  end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle floating-point add/subtract sequencer with valid/ready handshakes.
// FP_ROUND_EN selects round-to-nearest-even (ROUND state); otherwise results are truncated.
module fp_addsub_seq
  import fp_addsub_seq_pkg::*;
#(
  parameter int unsigned EXP_SIZE    = DEF_EXP_SIZE,
  parameter int unsigned MANTIS_SIZE = DEF_MANTIS_SIZE
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              op,
  input  logic [EXP_SIZE+MANTIS_SIZE:0]     a,
  input  logic [EXP_SIZE+MANTIS_SIZE:0]     b,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [EXP_SIZE+MANTIS_SIZE:0]     result,
  output logic [FLAG_W-1:0]                 flags
);

  localparam int unsigned W  = 1 + EXP_SIZE + MANTIS_SIZE;
  localparam int unsigned MW = MANTIS_SIZE + 3;
  localparam int unsigned DW = $clog2(MW + 1);

  state_t            state, state_d;
  logic              sx, sx_d, sub, sub_d;
  logic [EXP_SIZE-1:0] ex, ex_d;
  logic [MW-1:0]     mx, mx_d, my, my_d;
  logic [DW-1:0]     d, d_d;
  logic [W-1:0]      res_d;
  logic [FLAG_W-1:0] flags_d;
  logic              rdy_d, ov_d;

  logic                sa, sb, swap;
  logic [EXP_SIZE-1:0] ea, eb, ediff, ex_inc;
  logic [W-2:0]        mag_a, mag_b;
  logic [MW-1:0]       ma, mb;
  logic [DW-1:0]       d_clamp;
  logic [MW:0]         sum;

  // Operand unpack, magnitude compare and the single-cycle mantissa adder
  always_comb begin
    sa      = a[W-1];
    sb      = b[W-1] ^ op;
    ea      = a[W-2 -: EXP_SIZE];
    eb      = b[W-2 -: EXP_SIZE];
    mag_a   = (ea == '0) ? '0 : a[W-2:0];
    mag_b   = (eb == '0) ? '0 : b[W-2:0];
    ma      = (ea == '0) ? '0 : {1'b1, a[MANTIS_SIZE-1:0], 2'b00};
    mb      = (eb == '0) ? '0 : {1'b1, b[MANTIS_SIZE-1:0], 2'b00};
    swap    = (mag_b > mag_a);
    ediff   = swap ? (eb - ea) : (ea - eb);
    d_clamp = (32'(ediff) > MW) ? DW'(MW) : DW'(ediff);
    sum     = sub ? ({1'b0, mx} - {1'b0, my}) : ({1'b0, mx} + {1'b0, my});
    ex_inc  = ex + EXP_SIZE'(1);
  end

`ifdef FP_ROUND_EN
  logic [MANTIS_SIZE-1:0] rnd_frac;
  logic [EXP_SIZE-1:0]    rnd_exp;
  logic                   rnd_ovf;

  fp_round_unit #(
    .EXP_SIZE   (EXP_SIZE),
    .MANTIS_SIZE(MANTIS_SIZE)
  ) u_round (
    .mant    (mx),
    .expo    (ex),
    .frac    (rnd_frac),
    .expo_rnd(rnd_exp),
    .ovf     (rnd_ovf)
  );
`endif

  always_comb begin
    state_d = state;
    sx_d    = sx;
    sub_d   = sub;
    ex_d    = ex;
    mx_d    = mx;
    my_d    = my;
    d_d     = d;
    res_d   = result;
    flags_d = flags;
    rdy_d   = 1'b0;
    ov_d    = 1'b0;

    case (state)
      IDLE: begin
        if (in_valid) begin
          if (ea == {EXP_SIZE{1'b1}}) begin
            res_d   = a;
            flags_d = '0;
            state_d = DONE;
          end else if (eb == {EXP_SIZE{1'b1}}) begin
            res_d   = {sb, b[W-2:0]};
            flags_d = '0;
            state_d = DONE;
          end else begin
            sx_d    = swap ? sb : sa;
            ex_d    = swap ? eb : ea;
            mx_d    = swap ? mb : ma;
            my_d    = swap ? ma : mb;
            sub_d   = sa ^ sb;
            d_d     = d_clamp;
            state_d = ALIGN;
          end
        end
      end

      ALIGN: begin
        if (d == '0) begin
          state_d = ADD;
        end else begin
          my_d = {1'b0, my[MW-1:2], my[1] | my[0]};
          d_d  = d - DW'(1);
        end
      end

      ADD: begin
        if (sum[MW]) begin
          if (ex_inc == {EXP_SIZE{1'b1}}) begin
            res_d            = {sx, {EXP_SIZE{1'b1}}, {MANTIS_SIZE{1'b0}}};
            flags_d          = '0;
            flags_d[FLAG_OF] = 1'b1;
            state_d          = DONE;
          end else begin
            mx_d    = {sum[MW:2], sum[1] | sum[0]};
            ex_d    = ex_inc;
            state_d = NORM;
          end
        end else if (sum == '0) begin
          res_d              = '0;
          flags_d            = '0;
          flags_d[FLAG_ZERO] = 1'b1;
          state_d            = DONE;
        end else begin
          mx_d    = sum[MW-1:0];
          state_d = NORM;
        end
      end

      NORM: begin
        if (!mx[MW-1]) begin
          if (ex > EXP_SIZE'(1)) begin
            mx_d = {mx[MW-2:0], 1'b0};
            ex_d = ex - EXP_SIZE'(1);
          end else begin
            res_d              = {sx, {(W-1){1'b0}}};
            flags_d            = '0;
            flags_d[FLAG_UF]   = 1'b1;
            flags_d[FLAG_ZERO] = 1'b1;
            state_d            = DONE;
          end
        end else begin
`ifdef FP_ROUND_EN
          state_d = ROUND;
`else
          res_d                 = {sx, ex, mx[MW-2:2]};
          flags_d               = '0;
          flags_d[FLAG_INEXACT] = mx[1] | mx[0];
          state_d               = DONE;
`endif
        end
      end

`ifdef FP_ROUND_EN
      ROUND: begin
        flags_d               = '0;
        flags_d[FLAG_INEXACT] = mx[1] | mx[0];
        if (rnd_ovf) begin
          res_d            = {sx, {EXP_SIZE{1'b1}}, {MANTIS_SIZE{1'b0}}};
          flags_d[FLAG_OF] = 1'b1;
        end else begin
          res_d = {sx, rnd_exp, rnd_frac};
        end
        state_d = DONE;
      end
`endif

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Handshake outputs are registered images of the next state
    rdy_d = (state_d == IDLE);
    ov_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sx        <= 1'b0;
      sub       <= 1'b0;
      ex        <= '0;
      mx        <= '0;
      my        <= '0;
      d         <= '0;
      result    <= '0;
      flags     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      sx        <= sx_d;
      sub       <= sub_d;
      ex        <= ex_d;
      mx        <= mx_d;
      my        <= my_d;
      d         <= d_d;
      result    <= res_d;
      flags     <= flags_d;
      in_ready  <= rdy_d;
      out_valid <= ov_d;
    end
  end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed self-checking bench for fp_addsub_seq (EXP_SIZE=8, MANTIS_SIZE=23).
// Expectations follow FP_ROUND_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_fp_addsub_seq;

`ifdef FP_ROUND_EN
  localparam int          RL      = 1;
  localparam logic [31:0] R_SMALL = 32'h3F800001;
`else
  localparam int          RL      = 0;
  localparam logic [31:0] R_SMALL = 32'h3F800000;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        op;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  fp_addsub_seq #(
    .EXP_SIZE   (8),
    .MANTIS_SIZE(23)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .flags    (flags)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %h required %h", tag, obs, expv);
  endtask

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic iop);
    @(negedge clk);
    a        = ia;
    b        = ib;
    op       = iop;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts from the accept edge to the edge that first samples out_valid high
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                       input logic iop, input logic [31:0] er, input logic [3:0] ef,
                       input int el);
    int lat;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    issue(ia, ib, iop);
    wait_out(lat);
    check({tag, "_latency"}, 32'(lat), 32'(el));
    check({tag, "_result"}, result, er);
    check({tag, "_flags"}, 32'(flags), 32'(ef));
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready_rise"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", result, 32'h0);
    check("reset_flags", 32'(flags), 32'h0);

    do_op("one_plus_one",  32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 4 + RL);
    do_op("exact_cancel",  32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 4'b0010, 3);
    do_op("align24_round", 32'h3F800000, 32'h33C00000, 1'b0, R_SMALL,      4'b0001, 4 + RL + 24);
    do_op("align24_tie",   32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, 4 + RL + 24);
    do_op("overflow",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b1000, 3);
    do_op("align_clamp",   32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 4'b0001, 4 + RL + 26);
    do_op("special_a",     32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000, 1);
    do_op("special_b_neg", 32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000, 1);
    do_op("norm_one",      32'h3FC00000, 32'h3F800000, 1'b1, 32'h3F000000, 4'b0000, 4 + RL + 1);
    do_op("swap_negative", 32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000, 4 + RL + 2);
    do_op("underflow",     32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 4'b0110, 4);
    do_op("zero_minus_b",  32'h00000000, 32'h40400000, 1'b1, 32'hC0400000, 4'b0000, 4 + RL + 26);

    // Result must hold while the consumer stalls
    issue(32'h3F800000, 32'h3F800000, 1'b0);
    wait_out(lat);
    check("hold_latency", 32'(lat), 32'(4 + RL));
    repeat (10) @(posedge clk);
    #1;
    check("hold_out_valid", 32'(out_valid), 32'd1);
    check("hold_result", result, 32'h40000000);
    check("hold_flags", 32'(flags), 32'h0);
    check("hold_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("hold_release_valid", 32'(out_valid), 32'd0);
    check("hold_release_ready", 32'(in_ready), 32'd1);

    // Asynchronous reset in the middle of a long alignment
    issue(32'h3F800000, 32'h30800000, 1'b0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    check("midreset_result", result, 32'h0);
    check("midreset_flags", 32'(flags), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("postreset_out_valid", 32'(out_valid), 32'd0);
    do_op("postreset_op", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 4 + RL);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
